// File: rtl/cla_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial CLA adder.
package cla_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_core.sv
// Purely combinational 4-bit carry-lookahead adder; exposes the carry into
// bit 3 so the sequencer can form two's-complement overflow on the top nibble.
module cla4_core
    import cla_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co,
    output logic             c3
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic             c1;
    logic             c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum-of-products of g/p, so none waits on a lower carry.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit CLA,
// LSB nibble first, with a start/busy/done handshake and a registered result.
module cla_nibble_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] partial_next;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             last_nib;

    logic [NIB_W-1:0] core_a;
    logic [NIB_W-1:0] core_b;
    logic [NIB_W-1:0] core_s;
    logic             core_co;
    logic             core_c3;

    assign core_a = op_a[NIB_W*idx +: NIB_W];
    assign core_b = op_b[NIB_W*idx +: NIB_W];

    cla4_core u_core (
        .a  (core_a),
        .b  (core_b),
        .ci (carry),
        .s  (core_s),
        .co (core_co),
        .c3 (core_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        last_nib   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    last_nib   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The completed sum must include the nibble being written on the final edge.
    always_comb begin
        partial_next = partial;
        partial_next[NIB_W*idx +: NIB_W] = core_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            partial  <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a    <= a;
                        op_b    <= b;
                        carry   <= cin;
                        idx     <= '0;
                        partial <= '0;
                    end
                end
                RUN: begin
                    partial <= partial_next;
                    carry   <= core_co;
                    if (last_nib) begin
                        sum      <= partial_next;
                        cout     <= core_co;
                        overflow <= core_c3 ^ core_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
